// File: rtl/tri_root_seq.sv
// tri_root_seq: inverse triangular-number unit.
// Given S, returns the largest N with N(N+1)/2 <= S and the remainder
// R = S - N(N+1)/2 by subtracting 1, 2, 3, ... from an accumulator,
// one compare per clock, until the next step no longer fits.
module tri_root_seq #(
    parameter int unsigned SW = 7,
    parameter int unsigned NW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] S,
    output logic [NW-1:0] N,
    output logic [SW-1:0] R,
    output logic          exact,
    output logic          busy,
    output logic          done
);

    // Step counter needs one extra bit: at full-scale S it reaches 2^NW.
    localparam int unsigned KW = NW + 1;
    // Common width for the acc >= k compare so neither side is truncated.
    localparam int unsigned CW = (SW > KW) ? SW : KW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [SW-1:0]   acc;
    logic [SW-1:0]   acc_nxt;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_nxt;
    logic [NW-1:0]   n_cnt;
    logic [NW-1:0]   n_cnt_nxt;

    logic [NW-1:0]   n_out_nxt;
    logic [SW-1:0]   r_out_nxt;
    logic            exact_nxt;
    logic            busy_nxt;
    logic            done_nxt;

    logic            step_fits;

    // Next step fits in what is left of the sum; guards every subtraction.
    assign step_fits = (CW'(acc) >= CW'(k));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers; outputs are loaded from their next values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            k     <= '0;
            n_cnt <= '0;
            N     <= '0;
            R     <= '0;
            exact <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            k     <= k_nxt;
            n_cnt <= n_cnt_nxt;
            N     <= n_out_nxt;
            R     <= r_out_nxt;
            exact <= exact_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state, datapath update and registered-output next values.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        k_nxt     = k;
        n_cnt_nxt = n_cnt;
        n_out_nxt = N;
        r_out_nxt = R;
        exact_nxt = exact;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            // IDLE and DONE both accept a new request, giving back-to-back operation.
            IDLE, DONE: begin
                if (start) begin
                    acc_nxt   = S;
                    k_nxt     = KW'(1);
                    n_cnt_nxt = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end

            // One compare per cycle; start is ignored here.
            RUN: begin
                if (step_fits) begin
                    acc_nxt   = acc - SW'(k);
                    n_cnt_nxt = n_cnt + NW'(1);
                    k_nxt     = k + KW'(1);
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    n_out_nxt = n_cnt;
                    r_out_nxt = acc;
                    exact_nxt = (acc == '0);
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tri_root_seq.sv
// Self-checking bench for tri_root_seq against an arithmetic reference model.
module tb_tri_root_seq;

    localparam int unsigned SW = 7;
    localparam int unsigned NW = 4;
    localparam int MAX_CYC = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] S;
    logic [NW-1:0] N;
    logic [SW-1:0] R;
    logic          exact;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    tri_root_seq #(.SW(SW), .NW(NW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .S     (S),
        .N     (N),
        .R     (R),
        .exact (exact),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Forward sum unit: 1 + 2 + ... + n.
    function automatic int tri_num(input int n);
        return n * (n + 1) / 2;
    endfunction

    // Reference inverse: largest n whose triangular number fits, and the leftover.
    function automatic void ref_model(input int s, output int n, output int r);
        n = 0;
        while (tri_num(n + 1) <= s) n++;
        r = s - tri_num(n);
    endfunction

    // Issues one request at the current time (just after an edge) and waits for done.
    // cyc counts edges with the accepting edge as 1; busy_cyc counts busy samples.
    task automatic run_op(input int s, output int cyc, output int busy_cyc, output bit ok);
        start = 1'b1;
        S     = SW'(s);
        @(posedge clk); #1;
        start    = 1'b0;
        S        = SW'($urandom);
        cyc      = 1;
        busy_cyc = 0;
        ok       = 1'b0;
        while (cyc < MAX_CYC) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Checks one completed operation against the model (latency, N, R, exact).
    task automatic test_one(input string tag, input int s, input int cyc, input bit ok);
        int en, er;
        ref_model(s, en, er);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout s=%0d: no done within %0d cycles", tag, s, MAX_CYC);
            return;
        end
        checks++;
        if (cyc !== en + 2) begin
            errors++;
            $display("FAIL %s latency s=%0d: got %0d expected %0d", tag, s, cyc, en + 2);
        end
        checks++;
        if (int'(N) !== en || int'(R) !== er || exact !== (er == 0)) begin
            errors++;
            $display("FAIL %s result s=%0d: got N=%0d R=%0d exact=%0b expected N=%0d R=%0d exact=%0b",
                     tag, s, N, R, exact, en, er, (er == 0));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; S = '0;
        idle_cycles(2);
        checks++;
        if (N !== '0 || R !== '0 || exact !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got N=%0d R=%0d exact=%0b busy=%0b done=%0b expected all 0",
                     N, R, exact, busy, done);
        end
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_zero();
        int cyc, bc; bit ok;
        run_op(0, cyc, bc, ok);
        test_one("zero", 0, cyc, ok);
        checks++;
        if (bc !== 1) begin
            errors++;
            $display("FAIL zero_busy: got %0d busy cycles expected 1", bc);
        end
        idle_cycles(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: got done=%0b busy=%0b after DONE expected 0 0", done, busy);
        end
    endtask

    task automatic test_exact_points();
        int cyc, bc; bit ok;
        run_op(10, cyc, bc, ok);
        test_one("s10", 10, cyc, ok);
        idle_cycles(2);
        run_op(14, cyc, bc, ok);
        test_one("s14", 14, cyc, ok);
        // Results must hold while idle and S wanders.
        for (int i = 0; i < 4; i++) begin
            S = SW'($urandom);
            idle_cycles(1);
        end
        checks++;
        if (N !== NW'(4) || R !== SW'(4) || exact !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold: got N=%0d R=%0d exact=%0b done=%0b expected 4 4 0 0", N, R, exact, done);
        end
    endtask

    task automatic test_max();
        int cyc, bc; bit ok;
        run_op(127, cyc, bc, ok);
        test_one("max", 127, cyc, ok);
        checks++;
        if (bc !== 16 || N !== NW'(15) || R !== SW'(7)) begin
            errors++;
            $display("FAIL max_busy: got busy=%0d N=%0d R=%0d expected 16 15 7", bc, N, R);
        end
        idle_cycles(2);
    endtask

    task automatic test_start_during_run();
        int cyc, dones, done_cyc, dn, dr;
        start = 1'b1; S = SW'(100);
        @(posedge clk); #1;
        cyc = 1; dones = 0; done_cyc = 0; dn = -1; dr = -1;
        while (cyc < 40) begin
            start = (cyc < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            S     = SW'(5);
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = cyc; dn = int'(N); dr = int'(R);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL run_ignore_count: got %0d done pulses expected 1", dones);
        end
        checks++;
        if (dn !== 13 || dr !== 9 || done_cyc !== 15) begin
            errors++;
            $display("FAIL run_ignore_result: got N=%0d R=%0d at cycle %0d expected 13 9 at 15", dn, dr, done_cyc);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, bc, dones; bit ok;
        start = 1'b1; S = SW'(127);
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(4);
        rst = 1'b1;
        #1;
        checks++;
        if (N !== '0 || R !== '0 || exact !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: got N=%0d R=%0d exact=%0b busy=%0b done=%0b expected all 0",
                     N, R, exact, busy, done);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got %0d done pulses busy=%0b expected 0 0", dones, busy);
        end
        // Start on the very first edge after reset release.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        run_op(3, cyc, bc, ok);
        test_one("after_reset", 3, cyc, ok);
        checks++;
        if (N !== NW'(2) || R !== '0 || exact !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_val: got N=%0d R=%0d exact=%0b expected 2 0 1", N, R, exact);
        end
        idle_cycles(1);
    endtask

    task automatic test_random();
        int cyc, bc, s; bit ok;
        for (int i = 0; i < 30; i++) begin
            s = int'($urandom_range(0, 127));
            run_op(s, cyc, bc, ok);
            test_one("random", s, cyc, ok);
            idle_cycles(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; bit ok;
        for (int s = 0; s < 128; s++) begin
            run_op(s, cyc, bc, ok);
            test_one("sweep", s, cyc, ok);
            checks++;
            if (tri_num(int'(N)) + int'(R) !== s || R > SW'(N)) begin
                errors++;
                $display("FAIL sweep_identity s=%0d: got N=%0d R=%0d tri(N)+R=%0d", s, N, R,
                         tri_num(int'(N)) + int'(R));
            end
            if (!ok) break;
        end
        start = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_exact_points();
        test_max();
        test_start_during_run();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_root_seq.md
TRI_ROOT_SEQ -- requirements
Module: tri_root_seq

Interface
REQ-001 Parameter SW, default 7, sum input width in bits.
REQ-002 Parameter NW, default 4, term-count output width in bits; SW and NW SHALL satisfy 2^SW - 1 <= (2^NW - 1)(2^NW)/2 + 2^NW - 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request pulse; sampled on rising clk edge.
REQ-006 S  input  SW  sum to invert; sampled only when start is accepted.
REQ-007 N  output  NW  largest n with n(n+1)/2 <= S.
REQ-008 R  output  SW  remainder S - N(N+1)/2.
REQ-009 exact  output  1  high when R == 0.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 done  output  1  one-cycle pulse marking N, R and exact valid.

Function
REQ-012 The block SHALL be the inverse of the sum-of-first-N-integers unit: given S, it SHALL return N and R such that S = N(N+1)/2 + R and 0 <= R <= N.
REQ-013 FSM states SHALL be IDLE, RUN and DONE, registered, with no other reachable states.
REQ-014 IDLE: start=1 SHALL latch S into accumulator acc (SW bits), set step k=1 (NW+1 bits) and n=0, then go to RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN: per cycle, one compare; if acc >= k then acc <= acc - k, n <= n + 1, k <= k + 1, and stay in RUN; else go to DONE.
REQ-016 DONE: done=1 for exactly this one cycle; N=n, R=acc, exact=(acc==0); next state IDLE.
REQ-017 start in DONE SHALL be accepted exactly as in IDLE (back-to-back operation), with DONE -> RUN.
REQ-018 start while in RUN SHALL be ignored; latched operand and progress SHALL be unaffected.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 Latency: done SHALL assert on the (N+2)th rising edge after the edge that accepted start (N+1 RUN cycles, then DONE).
REQ-021 N, R and exact SHALL be registered and hold their last value until the next DONE; they change only on entry to DONE.
REQ-022 S=0 SHALL yield N=0, R=0, exact=1 after one RUN cycle.
REQ-023 S = 2^SW - 1 (127 at defaults) SHALL yield N=15, R=7, exact=0; k SHALL not overflow (max 16 in NW+1 bits).
REQ-024 All subtraction SHALL be unsigned and never underflow (guarded by the acc >= k compare).
REQ-025 Changes on S after start is accepted SHALL not affect the result.

Reset
REQ-026 rst=1 SHALL, asynchronously and in any state, force state=IDLE, acc=0, k=0, n=0, N=0, R=0, exact=0, busy=0, done=0.
REQ-027 Reset asserted during RUN SHALL abort the computation with no done pulse; after release the block SHALL accept a new start normally.
REQ-028 start asserted on the first edge after rst deassertion SHALL be accepted.

Verification
REQ-029 S=0, start pulse -> done 2 cycles later, N=0, R=0, exact=1, busy high 1 cycle.
REQ-030 S=10 -> N=4, R=0, exact=1, done at cycle 6; S=14 -> N=4, R=4, exact=0.
REQ-031 S=127 -> N=15, R=7, exact=0, done at cycle 17, busy high 16 cycles.
REQ-032 S=100 started, extra start pulses with S=5 during RUN -> result N=13, R=9; only one done pulse.
REQ-033 S=127 started, rst pulsed at RUN cycle 5 -> all outputs 0, no done; then start S=3 -> N=2, R=0, exact=1.
REQ-034 Sweep S=0..127 incrementing by 1, start re-asserted in DONE each time -> every result satisfies N(N+1)/2 + R == S and R <= N, and matches the forward sum unit driven with N.
